// File: rtl/i2c_master.sv
// Byte-level I2C master: one-register write or read (restart-based) against a 7-bit-addressed
// register slave. SCL is CLK/(4*CLK_DIV); SCL and SDA are open-drain (drive 0 or release).
module i2c_master #(
  parameter int         CLK_DIV  = 4,
  parameter logic [6:0] DEV_ADDR = 7'h55
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       RW,
  input  logic [7:0] INDEX,
  input  logic [7:0] WDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       NACK,
  output logic [7:0] RDATA,
  output wire        SCL,
  inout  wire        SDA,
  output logic [3:0] dbg_state
);

  // Request handshake: START is a strobe taken only in the cycle it is seen while BUSY is low;
  // RW/INDEX/WDATA are captured in that same cycle. BUSY stays high until DONE, which pulses
  // for exactly one cycle (including aborts); strobes while BUSY are dropped.

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_IDX, S_DATA_W, S_RESTART, S_ADDR_R, S_DATA_R, S_STOP
  } state_t;

  state_t     state, state_n;
  logic [7:0] div_cnt;
  logic [1:0] qtr;
  logic [3:0] bit_cnt;
  logic       rw_q;
  logic [7:0] index_q, wdata_q, rx_sh;
  logic       ack_hi;
  logic       tick, q_end, smp, ack_bit, accept;
  logic       scl_low, sda_low, byte_state;
  logic [7:0] tx_byte;

  assign tick    = (div_cnt == 8'(CLK_DIV - 1));
  assign q_end   = tick && (qtr == 2'd3);
  assign smp     = tick && (qtr == 2'd2);
  assign ack_bit = (bit_cnt == 4'd8);
  assign accept  = (state == S_IDLE) && START;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    scl_low    = 1'b0;
    sda_low    = 1'b0;
    byte_state = 1'b0;
    tx_byte    = 8'hFF;
    case (state)
      S_IDLE: if (START) state_n = S_START;
      S_START: begin
        sda_low = qtr[1];
        scl_low = (qtr == 2'd3);
        if (q_end) state_n = S_ADDR_W;
      end
      S_ADDR_W: begin
        byte_state = 1'b1;
        tx_byte    = {DEV_ADDR, 1'b0};
        if (q_end && ack_bit) state_n = ack_hi ? S_STOP : S_IDX;
      end
      S_IDX: begin
        byte_state = 1'b1;
        tx_byte    = index_q;
        if (q_end && ack_bit) state_n = ack_hi ? S_STOP : (rw_q ? S_RESTART : S_DATA_W);
      end
      S_DATA_W: begin
        byte_state = 1'b1;
        tx_byte    = wdata_q;
        if (q_end && ack_bit) state_n = S_STOP;
      end
      S_RESTART: begin
        scl_low = (qtr == 2'd0) || (qtr == 2'd3);
        sda_low = qtr[1];
        if (q_end) state_n = S_ADDR_R;
      end
      S_ADDR_R: begin
        byte_state = 1'b1;
        tx_byte    = {DEV_ADDR, 1'b1};
        if (q_end && ack_bit) state_n = ack_hi ? S_STOP : S_DATA_R;
      end
      S_DATA_R: begin
        // All-ones byte keeps SDA released for the slave's data and the final master NACK.
        byte_state = 1'b1;
        if (q_end && ack_bit) state_n = S_STOP;
      end
      S_STOP: begin
        scl_low = (qtr == 2'd0);
        sda_low = !qtr[1];
        if (q_end) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (byte_state) begin
      scl_low = (qtr == 2'd0) || (qtr == 2'd3);
      sda_low = !ack_bit && !tx_byte[~bit_cnt[2:0]];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= 8'd0;
      qtr     <= 2'd0;
      bit_cnt <= 4'd0;
      rw_q    <= 1'b0;
      index_q <= 8'h00;
      wdata_q <= 8'h00;
      rx_sh   <= 8'h00;
      ack_hi  <= 1'b0;
      DONE    <= 1'b0;
      NACK    <= 1'b0;
      RDATA   <= 8'h00;
    end else begin
      DONE <= 1'b0;
      if (accept) begin
        rw_q    <= RW;
        index_q <= INDEX;
        wdata_q <= WDATA;
        NACK    <= 1'b0;
        div_cnt <= 8'd0;
        qtr     <= 2'd0;
        bit_cnt <= 4'd0;
      end else if (state != S_IDLE) begin
        div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
        if (tick) qtr <= qtr + 2'd1;
        if (smp) begin
          ack_hi <= SDA;
          if (byte_state && ack_bit && state != S_DATA_R && SDA) NACK <= 1'b1;
          if (state == S_DATA_R && !ack_bit) rx_sh <= {rx_sh[6:0], SDA};
        end
        if (q_end) begin
          bit_cnt <= (byte_state && !ack_bit) ? bit_cnt + 4'd1 : 4'd0;
          if (state == S_DATA_R && ack_bit) RDATA <= rx_sh;
          if (state == S_STOP) DONE <= 1'b1;
        end
      end
    end
  end

  assign BUSY      = (state != S_IDLE);
  assign dbg_state = state;
  assign SCL       = scl_low ? 1'b0 : 1'bz;
  assign SDA       = sda_low ? 1'b0 : 1'bz;

endmodule
